// File: rtl/syscall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : syscall_ctrl
// Description : Syscall service controller. Print syscalls queue their operand
//               in a small FIFO that a display FSM drains, holding each value
//               on the display for DWELL cycles. A halt syscall stalls the
//               pipeline, waits for all queued prints to finish displaying,
//               then halts the CPU until the board "go" button is pressed.
// Ports       : clk, rst (async, active-high)
//               syscall/ra/rb  - syscall request, service code, print operand
//               go             - resume pulse from board button
//               stall, halt    - pipeline freeze / CPU halted
//               disp_data/disp_valid - displayed value and dwell-window flag
//               pending        - FIFO occupancy
//               sys_count      - accepted syscall count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_ctrl #(
    parameter int DEPTH = 4,
    parameter int DWELL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     syscall,
    input  logic [31:0]              ra,
    input  logic [31:0]              rb,
    input  logic                     go,
    output logic                     stall,
    output logic                     halt,
    output logic [31:0]              disp_data,
    output logic                     disp_valid,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [15:0]              sys_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_DW = $clog2(DWELL) + 1;

    localparam logic [c_CW-1:0] c_FULL         = c_CW'(DEPTH);
    localparam logic [c_DW-1:0] c_DWELL_RELOAD = c_DW'(DWELL - 1);
    localparam logic [31:0]     c_HALT_CODE    = 32'h0000_000A;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SHOW = 1'b1;

    logic [31:0]     r_mem [0:DEPTH-1];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [0:0]      r_state;
    logic [c_DW-1:0] r_dwell;
    logic [31:0]     r_disp_data;
    logic            r_disp_valid;
    logic            r_halt;
    logic            r_halt_pend;
    logic [15:0]     r_sys_count;

    logic w_stall;
    logic w_accept;
    logic w_is_halt;
    logic w_push;
    logic w_halt_req;
    logic w_has_data;
    logic w_pop;

    // Stall depends only on registered state so the pipeline never sees a
    // combinational loop through syscall.
    assign w_stall    = (r_count == c_FULL) | r_halt_pend | r_halt;
    assign w_accept   = syscall & ~w_stall;
    assign w_is_halt  = (ra == c_HALT_CODE);
    assign w_push     = w_accept & ~w_is_halt;
    assign w_halt_req = w_accept & w_is_halt;
    assign w_has_data = (r_count != '0);

    // The FSM takes the FIFO head when idle, or when the current dwell
    // window has just expired. Everything freezes while halted.
    assign w_pop = ~r_halt & w_has_data &
                   ((r_state == c_ST_IDLE) |
                    ((r_state == c_ST_SHOW) & (r_dwell == '0)));

    // Storage array carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= c_ST_IDLE;
            r_dwell      <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_halt       <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_sys_count  <= '0;
        end else begin
            // FIFO pointers and occupancy
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_accept) begin
                r_sys_count <= r_sys_count + 1'b1;
            end

            // Halt sequencing: a pending halt waits until every queued print
            // has completed its dwell and the display has gone idle.
            if (r_halt) begin
                if (go) begin
                    r_halt      <= 1'b0;
                    r_halt_pend <= 1'b0;
                end
            end else begin
                if (w_halt_req) begin
                    r_halt_pend <= 1'b1;
                end
                if (r_halt_pend && (r_count == '0) && (r_state == c_ST_IDLE)) begin
                    r_halt <= 1'b1;
                end
            end

            // Display FSM
            if (!r_halt) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_has_data) begin
                            r_disp_data  <= r_mem[r_rd_ptr];
                            r_dwell      <= c_DWELL_RELOAD;
                            r_disp_valid <= 1'b1;
                            r_state      <= c_ST_SHOW;
                        end
                    end
                    c_ST_SHOW: begin
                        if (r_dwell != '0) begin
                            r_dwell <= r_dwell - 1'b1;
                        end else if (w_has_data) begin
                            r_disp_data <= r_mem[r_rd_ptr];
                            r_dwell     <= c_DWELL_RELOAD;
                        end else begin
                            r_disp_valid <= 1'b0;
                            r_state      <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign stall      = w_stall;
    assign halt       = r_halt;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign pending    = r_count;
    assign sys_count  = r_sys_count;

endmodule
`default_nettype wire
